// File: rtl/irq_controller.sv
// Vectored interrupt controller: edge capture, masking, fixed priority with
// in-service nesting, and a mode-2 style vector returned on CPU acknowledge.
module irq_controller #(
   parameter int N_SRC = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] src,
   input  logic             cfg_we,
   input  logic             cfg_addr,
   input  logic [7:0]       cfg_wdata,
   input  logic             int_ack,
   input  logic             reti,
   output logic             int_req,
   output logic [7:0]       vec,
   output logic             vec_valid,
   output logic [N_SRC-1:0] in_service
);

   typedef enum logic [1:0] {IDLE, REQ, VEC} state_e;

   state_e           state_q, state_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] prev_q;
   logic [N_SRC-1:0] isv_q, isv_d;
   logic [3:0]       base_q, base_d;
   logic [2:0]       win_q, win_d;
   logic             req_q, vld_q;
   logic [7:0]       vec_q, vec_d;

   logic [N_SRC-1:0] elig;
   logic [N_SRC-1:0] isv_low;
   logic [N_SRC-1:0] win_oh;
   logic [2:0]       win_c;
   logic             any_elig;
   logic             blk;

   // A source is eligible only if no in-service bit sits at or above it in priority.
   always_comb begin
      blk  = 1'b0;
      elig = '0;
      for (int i = 0; i < N_SRC; i++) begin
         blk     = blk | isv_q[i];
         elig[i] = pend_q[i] & mask_q[i] & ~blk;
      end
   end

   always_comb begin
      win_c = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (elig[i]) win_c = 3'(i);
      end
   end

   assign any_elig = |elig;
   assign isv_low  = isv_q & (~isv_q + N_SRC'(1));
   assign win_oh   = N_SRC'(1) << win_q;

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      case (state_q)
         IDLE: if (any_elig) state_d = REQ;
         REQ: begin
            if (!any_elig) begin
               state_d = IDLE;
            end else if (int_ack) begin
               state_d = VEC;
               win_d   = win_c;
            end
         end
         VEC:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // New edges are OR-ed in after the service clear so a fresh edge wins.
   always_comb begin
      pend_d = pend_q;
      isv_d  = isv_q;
      if (state_q == VEC) pend_d = pend_d & ~win_oh;
      pend_d = pend_d | (src & ~prev_q & mask_q);
      if (reti) isv_d = isv_d & ~isv_low;
      if (state_q == VEC) isv_d = isv_d | win_oh;
   end

   always_comb begin
      mask_d = mask_q;
      base_d = base_q;
      if (cfg_we && !cfg_addr) mask_d = cfg_wdata[N_SRC-1:0];
      if (cfg_we && cfg_addr)  base_d = cfg_wdata[7:4];
   end

   // Vector byte is captured at acknowledge so a concurrent base write cannot leak in.
   assign vec_d = (state_d == VEC) ? {base_q, win_c, 1'b0} : 8'h00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mask_q  <= '0;
         pend_q  <= '0;
         prev_q  <= '0;
         isv_q   <= '0;
         base_q  <= '0;
         win_q   <= '0;
         req_q   <= 1'b0;
         vld_q   <= 1'b0;
         vec_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         prev_q  <= src;
         isv_q   <= isv_d;
         base_q  <= base_d;
         win_q   <= win_d;
         req_q   <= (state_d == REQ);
         vld_q   <= (state_d == VEC);
         vec_q   <= vec_d;
      end
   end

   assign int_req    = req_q;
   assign vec_valid  = vld_q;
   assign vec        = vec_q;
   assign in_service = isv_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the interrupt rules.
module tb_irq_controller;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] src = '0;
   logic         cfg_we = 1'b0;
   logic         cfg_addr = 1'b0;
   logic [7:0]   cfg_wdata = '0;
   logic         int_ack = 1'b0;
   logic         reti = 1'b0;
   logic         int_req;
   logic [7:0]   vec;
   logic         vec_valid;
   logic [N-1:0] in_service;

   irq_controller #(.N_SRC(N)) dut (
      .clk(clk), .rst_n(rst_n), .src(src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .int_ack(int_ack), .reti(reti), .int_req(int_req),
      .vec(vec), .vec_valid(vec_valid), .in_service(in_service)
   );

   always #5 clk = ~clk;

   int n_tot = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: plain bit vectors and a couple of flags describing
   // what the CPU should see on the next cycle.
   bit [7:0] m_mask, m_base, m_pend, m_prev, m_isv, m_vbyte;
   bit       m_req, m_vec;
   int       m_win;

   task automatic model_reset();
      m_mask = 0; m_base = 0; m_pend = 0; m_prev = 0; m_isv = 0; m_vbyte = 0;
      m_req = 0; m_vec = 0; m_win = 0;
   endtask

   // Highest-priority pending+enabled source that outranks every handler in service.
   function automatic int m_winner();
      for (int i = 0; i < N; i++) begin
         if (m_isv[i]) return -1;
         if (m_pend[i] && m_mask[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step();
      int w;
      bit [7:0] np, ni;
      if (!rst_n) begin
         model_reset();
         return;
      end
      w  = m_winner();
      np = m_pend;
      ni = m_isv;
      if (m_vec) np[m_win] = 1'b0;
      np = np | (src & ~m_prev & m_mask);
      if (reti) ni = m_isv & (m_isv - 8'd1);
      if (m_vec) ni[m_win] = 1'b1;
      if (m_vec) begin
         m_vec = 0;
         m_req = 0;
      end else if (m_req) begin
         if (w < 0) m_req = 0;
         else if (int_ack) begin
            m_req = 0;
            m_vec = 1;
            m_win = w;
            m_vbyte = (m_base & 8'hF0) | 8'(w * 2);
         end
      end else begin
         m_req = (w >= 0);
      end
      if (cfg_we) begin
         if (cfg_addr) m_base = cfg_wdata & 8'hF0;
         else          m_mask = cfg_wdata;
      end
      m_pend = np;
      m_isv  = ni;
      m_prev = src;
   endtask

   task automatic compare_all();
      check("int_req", {31'd0, int_req}, {31'd0, m_req});
      check("vec_valid", {31'd0, vec_valid}, {31'd0, m_vec});
      check("vec", {24'd0, vec}, {24'd0, (m_vec ? m_vbyte : 8'h00)});
      check("in_service", {24'd0, in_service}, {24'd0, m_isv});
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic cfg_write(input logic addr, input logic [7:0] data);
      cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
      tick();
      cfg_we = 1'b0;
   endtask

   // Returns two cycles after the edge, where int_req should be visible.
   task automatic pulse_src(input logic [7:0] v);
      src = v;
      tick();
      src = '0;
      tick();
      tick();
   endtask

   task automatic ack_cycle();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic reti_cycle();
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_req", {31'd0, int_req}, 32'd0);
      check("rst_vv", {31'd0, vec_valid}, 32'd0);
      check("rst_vec", {24'd0, vec}, 32'd0);
      check("rst_isv", {24'd0, in_service}, 32'd0);
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #1;
      check("init_req", {31'd0, int_req}, 32'd0);
      check("init_vec", {24'd0, vec}, 32'd0);
      check("init_vv", {31'd0, vec_valid}, 32'd0);
      check("init_isv", {24'd0, in_service}, 32'd0);
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      tick();

      // single source, basic vector
      cfg_write(1'b0, 8'h01);
      cfg_write(1'b1, 8'h40);
      pulse_src(8'h01);
      check("t1_req", {31'd0, int_req}, 32'd1);
      ack_cycle();
      check("t1_vv", {31'd0, vec_valid}, 32'd1);
      check("t1_vec", {24'd0, vec}, 32'h40);
      check("t1_req_drop", {31'd0, int_req}, 32'd0);
      tick();
      check("t1_vv_once", {31'd0, vec_valid}, 32'd0);
      check("t1_isv", {24'd0, in_service}, 32'h01);
      reti_cycle();
      check("t1_reti", {24'd0, in_service}, 32'h00);

      // two simultaneous edges, lower one waits for reti
      cfg_write(1'b0, 8'hFF);
      pulse_src(8'h24);
      check("t2_req", {31'd0, int_req}, 32'd1);
      ack_cycle();
      check("t2_vec1", {24'd0, vec}, 32'h44);
      tick();
      repeat (4) tick();
      check("t2_blocked", {31'd0, int_req}, 32'd0);
      check("t2_isv", {24'd0, in_service}, 32'h04);
      reti_cycle();
      tick();
      tick();
      check("t2_req_r3", {31'd0, int_req}, 32'd1);
      ack_cycle();
      check("t2_vec2", {24'd0, vec}, 32'h4A);
      tick();
      reti_cycle();

      // nesting: higher pre-empts, lower is held off
      pulse_src(8'h08);
      ack_cycle();
      tick();
      check("t3_isv3", {24'd0, in_service}, 32'h08);
      pulse_src(8'h02);
      check("t3_nest_req", {31'd0, int_req}, 32'd1);
      ack_cycle();
      check("t3_vec", {24'd0, vec}, 32'h42);
      tick();
      check("t3_isv13", {24'd0, in_service}, 32'h0A);
      pulse_src(8'h40);
      repeat (3) tick();
      check("t3_low_blocked", {31'd0, int_req}, 32'd0);
      reti_cycle();
      check("t3_reti_low", {24'd0, in_service}, 32'h08);
      repeat (3) tick();
      check("t3_still_blocked", {31'd0, int_req}, 32'd0);
      reti_cycle();
      tick();
      tick();
      check("t3_req6", {31'd0, int_req}, 32'd1);
      ack_cycle();
      check("t3_vec6", {24'd0, vec}, 32'h4C);
      tick();
      reti_cycle();

      // masked edge is discarded
      cfg_write(1'b0, 8'h00);
      pulse_src(8'h10);
      cfg_write(1'b0, 8'h10);
      repeat (4) tick();
      check("t4_discard", {31'd0, int_req}, 32'd0);

      // mask cleared while requesting; late ack yields nothing
      cfg_write(1'b0, 8'h01);
      pulse_src(8'h01);
      check("t5_req", {31'd0, int_req}, 32'd1);
      cfg_write(1'b0, 8'h00);
      tick();
      check("t5_drop", {31'd0, int_req}, 32'd0);
      ack_cycle();
      check("t5_late_vv", {31'd0, vec_valid}, 32'd0);
      check("t5_late_vec", {24'd0, vec}, 32'h00);

      // re-enable the stale pending bit, then reset in REQ
      cfg_write(1'b0, 8'h01);
      tick();
      check("t6_req", {31'd0, int_req}, 32'd1);
      do_reset();
      repeat (3) tick();
      check("t6_no_stale", {31'd0, int_req}, 32'd0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         src       = src ^ 8'($urandom & $urandom & $urandom);
         cfg_we    = ($urandom_range(0, 15) == 0);
         cfg_addr  = 1'($urandom_range(0, 1));
         cfg_wdata = 8'($urandom);
         int_ack   = int_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         reti      = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 399) == 0) do_reset();
         else tick();
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
